// File: rtl/adc_playback_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_playback_pkg
//  Description : Shared state encodings, GPIO field positions and saturation
//                helper for the ADC playback injector.
//  Revision    : 1.0 - initial release
// ============================================================================
package adc_playback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Control word fields
    localparam int CTRL_ARM_BIT   = 0;
    localparam int CTRL_LOOP_BIT  = 1;
    localparam int CTRL_CLEAR_BIT = 2;
    localparam int CTRL_LAST_LSB  = 4;
    localparam int CTRL_LAST_W    = 12;
    localparam int CTRL_RATE_LSB  = 16;
    localparam int CTRL_RATE_W    = 16;

    // Table write word fields
    localparam int WD_TOGGLE_BIT  = 31;
    localparam int WD_ADDR_LSB    = 16;
    localparam int WD_DATA_LSB    = 0;

    // Status word fields
    localparam int STS_STATE_LSB  = 30;
    localparam int STS_WRAP_LSB   = 20;
    localparam int STS_WRCNT_LSB  = 12;
    localparam int STS_RDPTR_LSB  = 0;
    localparam int STS_RDPTR_W    = 12;

    localparam logic [7:0] SAT_LIMIT = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == SAT_LIMIT) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inj_sdp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : inj_sdp_ram
//  Description : Simple dual-port sample table, read-first, registered read,
//                no reset so it maps onto block RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module inj_sdp_ram #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Non-blocking write and read in one process give read-first collisions.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/adc_playback_injector.sv
`default_nettype none
// ============================================================================
//  Module      : adc_playback_injector
//  Description : Plays a GPIO-loaded sample table out as an ADC-like stream
//                at a programmable rate, one-shot or looped.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_playback_injector
    import adc_playback_pkg::*;
#(
    parameter int ADC_WIDTH  = 14,
    parameter int GPIO_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [GPIO_WIDTH-1:0] gpio_ctrl,
    input  logic [GPIO_WIDTH-1:0] gpio_wdata,
    output logic [ADC_WIDTH-1:0]  inj_data,
    output logic                  inj_valid,
    output logic                  busy,
    output logic [GPIO_WIDTH-1:0] status_out
);

    localparam logic [CTRL_LAST_W-1:0] MAX_ADDR = CTRL_LAST_W'((1 << ADDR_WIDTH) - 1);

    logic                   arm;
    logic                   loop_en;
    logic                   clear;
    logic [CTRL_LAST_W-1:0] last_raw;
    logic [ADDR_WIDTH-1:0]  last_addr;
    logic [CTRL_RATE_W-1:0] rate_div;
    logic                   wr_en;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [ADC_WIDTH-1:0]   wr_data;
    logic                   rd_en;
    logic [ADC_WIDTH-1:0]   ram_rdata;
    logic                   unused_bits;

    state_e                 state_q,     state_d;
    logic                   arm_q;
    logic                   tog_q;
    logic [ADDR_WIDTH-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [CTRL_RATE_W-1:0] div_cnt_q,   div_cnt_d;
    logic [7:0]             wrap_cnt_q,  wrap_cnt_d;
    logic [7:0]             wr_count_q,  wr_count_d;
    logic                   inj_valid_q, inj_valid_d;
    logic                   have_data_q, have_data_d;

    assign arm      = gpio_ctrl[CTRL_ARM_BIT];
    assign loop_en  = gpio_ctrl[CTRL_LOOP_BIT];
    assign clear    = gpio_ctrl[CTRL_CLEAR_BIT];
    assign last_raw = gpio_ctrl[CTRL_LAST_LSB +: CTRL_LAST_W];
    assign rate_div = gpio_ctrl[CTRL_RATE_LSB +: CTRL_RATE_W];

    assign last_addr = (last_raw > MAX_ADDR) ? MAX_ADDR[ADDR_WIDTH-1:0]
                                             : last_raw[ADDR_WIDTH-1:0];

    assign wr_en   = gpio_wdata[WD_TOGGLE_BIT] ^ tog_q;
    assign wr_addr = gpio_wdata[WD_ADDR_LSB +: ADDR_WIDTH];
    assign wr_data = gpio_wdata[WD_DATA_LSB +: ADC_WIDTH];

    assign unused_bits = ^{gpio_ctrl, gpio_wdata};

    inj_sdp_ram #(
        .DATA_WIDTH (ADC_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        div_cnt_d   = div_cnt_q;
        wrap_cnt_d  = wrap_cnt_q;
        wr_count_d  = wr_count_q;
        rd_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm && !arm_q) begin
                    state_d   = ST_PLAY;
                    rd_ptr_d  = '0;
                    div_cnt_d = '0;
                end
            end
            ST_PLAY: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                // >= keeps the divider from running away if rate_div drops mid-count
                end else if (div_cnt_q >= rate_div) begin
                    rd_en     = 1'b1;
                    div_cnt_d = '0;
                    if (rd_ptr_q == last_addr) begin
                        if (loop_en) begin
                            rd_ptr_d   = '0;
                            wrap_cnt_d = sat_inc(wrap_cnt_q);
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + CTRL_RATE_W'(1);
                end
            end
            ST_DONE: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_en) begin
            wr_count_d = sat_inc(wr_count_q);
        end
        if (clear) begin
            wrap_cnt_d = '0;
            wr_count_d = '0;
        end

        inj_valid_d = rd_en;
        have_data_d = have_data_q | rd_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            arm_q       <= 1'b0;
            tog_q       <= 1'b0;
            rd_ptr_q    <= '0;
            div_cnt_q   <= '0;
            wrap_cnt_q  <= '0;
            wr_count_q  <= '0;
            inj_valid_q <= 1'b0;
            have_data_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_q       <= arm;
            tog_q       <= gpio_wdata[WD_TOGGLE_BIT];
            rd_ptr_q    <= rd_ptr_d;
            div_cnt_q   <= div_cnt_d;
            wrap_cnt_q  <= wrap_cnt_d;
            wr_count_q  <= wr_count_d;
            inj_valid_q <= inj_valid_d;
            have_data_q <= have_data_d;
        end
    end

    // RAM output is unreset; gate it so inj_data reads 0 until a sample lands.
    assign inj_data  = have_data_q ? ram_rdata : '0;
    assign inj_valid = inj_valid_q;
    assign busy      = (state_q == ST_PLAY);

    always_comb begin
        status_out = '0;
        status_out[STS_STATE_LSB +: 2]           = state_q;
        status_out[STS_WRAP_LSB  +: 8]           = wrap_cnt_q;
        status_out[STS_WRCNT_LSB +: 8]           = wr_count_q;
        status_out[STS_RDPTR_LSB +: STS_RDPTR_W] = STS_RDPTR_W'(rd_ptr_q);
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_playback_injector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_playback_injector
//  Description : Directed self-checking bench for adc_playback_injector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_playback_injector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] gpio_ctrl;
    logic [31:0] gpio_wdata;
    logic [13:0] inj_data;
    logic        inj_valid;
    logic        busy;
    logic [31:0] status_out;

    int   total = 0;
    int   bad   = 0;
    logic tog   = 1'b0;

    always #5 clk = ~clk;

    adc_playback_injector #(
        .ADC_WIDTH  (14),
        .GPIO_WIDTH (32),
        .ADDR_WIDTH (10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gpio_ctrl  (gpio_ctrl),
        .gpio_wdata (gpio_wdata),
        .inj_data   (inj_data),
        .inj_valid  (inj_valid),
        .busy       (busy),
        .status_out (status_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ctrl(input bit arm, input bit lp, input bit clr,
                                         input int last, input int rate);
        return {16'(rate), 12'(last), 1'b0, clr, lp, arm};
    endfunction

    task automatic wr(input int addr, input logic [13:0] d);
        tog        = ~tog;
        gpio_wdata = {tog, 1'b0, 14'(addr), 2'b00, d};
        tick();
    endtask

    function automatic logic [31:0] sx(input logic [13:0] d);
        return 32'($signed(d));
    endfunction

    function automatic logic [31:0] st(input logic [31:0] s);
        return {30'd0, s[31:30]};
    endfunction

    int exp_os [4] = '{16, 8191, -8192, -1};

    initial begin
        int n;
        rst_n      = 1'b0;
        gpio_ctrl  = '0;
        gpio_wdata = '0;
        repeat (3) tick();
        check("rst_valid",  {31'd0, inj_valid}, 32'd0);
        check("rst_busy",   {31'd0, busy},      32'd0);
        check("rst_data",   {18'd0, inj_data},  32'd0);
        check("rst_status", status_out,         32'd0);
        rst_n = 1'b1;
        tick();

        // Table load: four back-to-back toggles, then hold
        wr(0, 14'h0010);
        wr(1, 14'h1FFF);
        wr(2, 14'h2000);
        wr(3, 14'h3FFF);
        tick();
        tick();
        check("wr_count4", {24'd0, status_out[19:12]}, 32'd4);

        // One-shot at full rate
        gpio_ctrl = ctrl(1, 0, 0, 3, 0);
        tick();
        for (int c = 1; c <= 6; c++) begin
            if (c == 1) check("os_busy1", {31'd0, busy}, 32'd1);
            check($sformatf("os_valid_c%0d", c), {31'd0, inj_valid},
                  (c >= 2 && c <= 5) ? 32'd1 : 32'd0);
            if (c >= 2 && c <= 5)
                check($sformatf("os_data_c%0d", c), sx(inj_data), 32'(exp_os[c-2]));
            if (c == 5) begin
                check("os_state_done", st(status_out), 32'd2);
                check("os_busy_done",  {31'd0, busy}, 32'd0);
            end
            tick();
        end
        repeat (3) tick();
        check("done_hold",  st(status_out), 32'd2);
        check("done_nodata", {31'd0, inj_valid}, 32'd0);
        check("done_hold_data", sx(inj_data), 32'(-1));
        gpio_ctrl = ctrl(0, 0, 0, 3, 0);
        tick();
        check("done_to_idle", st(status_out), 32'd0);
        tick();

        // Looped with rate_div=2: strobes every 3 cycles, 16/8191 alternating
        gpio_ctrl = ctrl(1, 1, 0, 1, 2);
        tick();
        for (int c = 1; c <= 14; c++) begin
            bit ev;
            ev = (c >= 4) && (((c - 4) % 3) == 0);
            check($sformatf("lp_valid_c%0d", c), {31'd0, inj_valid}, ev ? 32'd1 : 32'd0);
            if (ev)
                check($sformatf("lp_data_c%0d", c), sx(inj_data),
                      ((((c - 4) / 3) % 2) != 0) ? 32'd8191 : 32'd16);
            if (c == 8)  check("lp_wrap1", {24'd0, status_out[27:20]}, 32'd1);
            if (c == 14) check("lp_wrap2", {24'd0, status_out[27:20]}, 32'd2);
            tick();
        end
        gpio_ctrl = ctrl(1, 1, 1, 1, 2);
        repeat (7) tick();
        check("clr_wrap",  {24'd0, status_out[27:20]}, 32'd0);
        check("clr_wrcnt", {24'd0, status_out[19:12]}, 32'd0);
        check("clr_busy",  {31'd0, busy}, 32'd1);
        gpio_ctrl = '0;
        repeat (3) tick();
        check("lp_stop_idle", st(status_out), 32'd0);

        // Abort after the second read (rate_div=1: reads in cycles 2 and 4)
        gpio_ctrl = ctrl(1, 0, 0, 3, 1);
        tick();
        n = 0;
        for (int c = 1; c <= 10; c++) begin
            if (inj_valid) n++;
            if (c == 6) check("ab_state_idle", st(status_out), 32'd0);
            if (c == 5) gpio_ctrl = ctrl(0, 0, 0, 3, 1);
            tick();
        end
        check("ab_strobes", 32'(n), 32'd2);

        // Re-arm looping at full rate; collide a write on address 1 in cycle 2
        gpio_ctrl = ctrl(1, 1, 0, 3, 0);
        tick();
        for (int c = 1; c <= 8; c++) begin
            if (c == 2) check("rearm_first", sx(inj_data), 32'd16);
            if (c == 3) begin
                check("col_valid", {31'd0, inj_valid}, 32'd1);
                check("col_old",   sx(inj_data), 32'd8191);
            end
            if (c == 7) begin
                check("col_new_valid", {31'd0, inj_valid}, 32'd1);
                check("col_new", sx(inj_data), 32'h0AAA);
            end
            if (c == 2) begin
                tog        = ~tog;
                gpio_wdata = {tog, 1'b0, 14'd1, 2'b00, 14'h0AAA};
            end
            tick();
        end
        check("col_wrcnt", {24'd0, status_out[19:12]}, 32'd1);
        gpio_ctrl = '0;
        repeat (3) tick();

        // Async reset between a read and its strobe
        gpio_ctrl = ctrl(1, 0, 0, 3, 0);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_valid",  {31'd0, inj_valid}, 32'd0);
        check("ar_busy",   {31'd0, busy},      32'd0);
        check("ar_data",   {18'd0, inj_data},  32'd0);
        check("ar_status", status_out,         32'd0);
        tick();
        check("ar_no_strobe", {31'd0, inj_valid}, 32'd0);
        gpio_ctrl = '0;
        rst_n     = 1'b1;
        tick();
        tick();
        check("ar_idle", st(status_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
